// File: rtl/bitstream_gen.sv
// bitstream_gen: 4-channel unary bitstream generator, one value set per 2**WIDTH-slot frame.
// Define BITSTREAM_LFSR_EN to scramble slot order with a maximal-length LFSR reference.
module bitstream_gen #(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] SEED  = 4'b1001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] val1,
  input  logic [WIDTH-1:0] val2,
  input  logic [WIDTH-1:0] val3,
  input  logic [WIDTH-1:0] val4,
  output logic             bs1,
  output logic             bs2,
  output logic             bs3,
  output logic             bs4,
  output logic             en_out
);
  localparam int               FRAME = 2**WIDTH;
  localparam logic [WIDTH-1:0] LAST  = WIDTH'(FRAME-1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t                      state_q;
  logic [WIDTH-1:0]            cnt_q, ref_d;
  logic                        pend_vld_q, en_q, acc, due, src;
  logic [3:0]                  bs_q, bs_d;
  logic [3:0][WIDTH-1:0]       vals, act_q, shd_q, act_d;
  if (SEED == '0) begin : g_bad_seed
    $error("SEED must be nonzero");
  end
  assign vals     = {val4, val3, val2, val1};
  assign in_ready = !pend_vld_q;
  assign acc      = in_valid && in_ready;
  assign due      = state_q == IDLE || cnt_q == LAST;
  assign src      = pend_vld_q || acc;
  assign act_d    = (due && src) ? (pend_vld_q ? shd_q : vals) : act_q;
`ifdef BITSTREAM_LFSR_EN
  // lfsr_q holds the reference of the visible slot; the last slot forces 0 so every value appears once
  localparam logic [WIDTH-1:0] PEN = WIDTH'(FRAME-2);
  logic [WIDTH-1:0] lfsr_q, lfsr_step;
  assign lfsr_step = {lfsr_q[WIDTH-2:0], lfsr_q[WIDTH-1] ^ lfsr_q[WIDTH-2]};
  assign ref_d     = due ? SEED : (cnt_q == PEN ? '0 : lfsr_step);
  always_ff @(posedge clk or negedge rst)
    if (!rst) lfsr_q <= SEED;
    else      lfsr_q <= ref_d;
`else
  assign ref_d = due ? '0 : cnt_q + 1'b1;
`endif
  always_comb begin
    for (int i = 0; i < 4; i++) bs_d[i] = act_d[i] > ref_d;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pend_vld_q <= 1'b0;
      act_q      <= '0;
      shd_q      <= '0;
      bs_q       <= '0;
      en_q       <= 1'b0;
    end else if (due) begin
      state_q    <= src ? RUN : IDLE;
      cnt_q      <= '0;
      pend_vld_q <= 1'b0;
      act_q      <= act_d;
      bs_q       <= src ? bs_d : '0;
      en_q       <= src;
    end else begin
      cnt_q <= cnt_q + 1'b1;
      bs_q  <= bs_d;
      if (acc) begin
        shd_q      <= vals;
        pend_vld_q <= 1'b1;
      end
    end
  end
  assign {bs4, bs3, bs2, bs1} = bs_q;
  assign en_out               = en_q;
endmodule

// File: tb/tb_bitstream_gen.sv
// tb_bitstream_gen: directed checks of framing, chaining, backpressure and reset for bitstream_gen.
module tb_bitstream_gen;
  logic       clk = 1'b0, rst = 1'b0, in_valid = 1'b0;
  logic       in_ready, bs1, bs2, bs3, bs4, en_out;
  logic [3:0] val1 = '0, val2 = '0, val3 = '0, val4 = '0;
  int         passed = 0, total = 0;
  logic [3:0] seq[16], seq_prev[16];
  bitstream_gen dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .val1(val1), .val2(val2), .val3(val3), .val4(val4),
    .bs1(bs1), .bs2(bs2), .bs3(bs3), .bs4(bs4), .en_out(en_out)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic setv(input logic [15:0] v);
    {val4, val3, val2, val1} = v;
  endtask
  task automatic load(input logic [15:0] v);
    setv(v);
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
  endtask
  // Walks one frame from slot 0; optionally offers nxt at slot acc, and with hld keeps in_valid high on junk
  task automatic frame(input string tag, input logic [15:0] v, input int acc, input logic [15:0] nxt,
                       input logic hld);
    int         c[4];
    logic [3:0] e;
    c = '{0, 0, 0, 0};
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 4; i++) e[i] = v[4*i +: 4] > k;
`ifdef BITSTREAM_LFSR_EN
      check($sformatf("%s en s%0d", tag, k), en_out, 1);
`else
      check($sformatf("%s s%0d", tag, k), {en_out, bs4, bs3, bs2, bs1}, {1'b1, e});
`endif
      check($sformatf("%s rdy s%0d", tag, k), in_ready, (acc < 0 || acc >= 15 || k <= acc));
      seq[k] = {bs4, bs3, bs2, bs1};
      for (int i = 0; i < 4; i++) c[i] += seq[k][i];
      if (k == acc) begin
        setv(nxt);
        in_valid = 1'b1;
      end
      tick;
      if (k == acc) begin
        if (hld) setv(16'hFFFF);
        else in_valid = 1'b0;
      end
    end
    for (int i = 0; i < 4; i++) check($sformatf("%s ones ch%0d", tag, i + 1), c[i], v[4*i +: 4]);
  endtask
  initial begin
    tick;
    check("reset out", {en_out, bs4, bs3, bs2, bs1}, 0);
    check("reset rdy", in_ready, 1);
    tick;
    rst = 1'b1;
    tick;
    check("idle out", {en_out, bs4, bs3, bs2, bs1}, 0);
    // 1: ramp
    load(16'h8F05);
    frame("ramp", 16'h8F05, -1, 16'h0, 1'b0);
    check("ramp end", {en_out, bs4, bs3, bs2, bs1}, 0);
    check("ramp end rdy", in_ready, 1);
    // 2: back-to-back through the shadow register
    load(16'h4321);
    frame("b2b A", 16'h4321, 3, 16'h27AC, 1'b0);
    frame("b2b B", 16'h27AC, -1, 16'h0, 1'b0);
    check("b2b end", {en_out, bs4, bs3, bs2, bs1}, 0);
    // 3: direct chain at the last slot
    load(16'h1234);
    frame("chain A", 16'h1234, 15, 16'hE0F6, 1'b0);
    frame("chain B", 16'hE0F6, -1, 16'h0, 1'b0);
    check("chain end", {en_out, bs4, bs3, bs2, bs1}, 0);
    // 4: backpressure with a full shadow
    load(16'h5555);
    frame("bp A", 16'h5555, 2, 16'h3A9C, 1'b1);
    in_valid = 1'b0;
    frame("bp B", 16'h3A9C, -1, 16'h0, 1'b0);
    check("bp end", {en_out, bs4, bs3, bs2, bs1}, 0);
    // 5: reset mid-frame with a pending set
    load(16'hFFFF);
    setv(16'h9999);
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    check("rst pend rdy", in_ready, 0);
    repeat (6) tick;
    check("rst slot7 en", en_out, 1);
    rst = 1'b0;
    #1;
    check("rst async out", {en_out, bs4, bs3, bs2, bs1}, 0);
    check("rst async rdy", in_ready, 1);
    tick;
    tick;
    rst = 1'b1;
    for (int k = 0; k < 20; k++) begin
      check($sformatf("post rst c%0d", k), {en_out, bs4, bs3, bs2, bs1}, 0);
      tick;
    end
    load(16'h6A31);
    frame("post rst", 16'h6A31, -1, 16'h0, 1'b0);
    // 6: repeatability and last-slot reference
    load(16'hF910);
    frame("rep 1", 16'hF910, -1, 16'h0, 1'b0);
    for (int k = 0; k < 16; k++) seq_prev[k] = seq[k];
    tick;
    load(16'hF910);
    frame("rep 2", 16'hF910, -1, 16'h0, 1'b0);
    for (int k = 0; k < 16; k++) check($sformatf("rep s%0d", k), seq[k], seq_prev[k]);
`ifdef BITSTREAM_LFSR_EN
    check("last slot", seq[15], 4'b1110);
`else
    check("last slot", seq[15], 4'b0000);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
